// File: rtl/pc_phase_sequencer.sv
// Multicycle instruction phase sequencer: boot delay, stall/flush, PC load enable and retired count.
// Optional single-step launch from IDLE is enabled by defining PCSEQ_SINGLE_STEP_EN.
module pc_phase_sequencer #(
  parameter int unsigned PHASES      = 5,
  parameter int unsigned PHASE_W     = 3,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned RET_W       = 16
) (
  input  logic               PCSEQ_Clk,
  input  logic               PCSEQ_Reset,
  input  logic               PCSEQ_En,
  input  logic               PCSEQ_Stall,
  input  logic               PCSEQ_Flush,
`ifdef PCSEQ_SINGLE_STEP_EN
  input  logic               PCSEQ_Step,
`endif
  output logic               PCSEQ_Set_En,
  output logic [PHASE_W-1:0] PCSEQ_Phase,
  output logic               PCSEQ_Phase_Valid,
  output logic [RET_W-1:0]   PCSEQ_Retired
);

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_RUN} state_t;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);
  localparam int unsigned        BOOT_LAST_I = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
  localparam logic [3:0]         BOOT_LAST   = 4'(BOOT_LAST_I);
  // With no boot delay the sequencer comes out of reset straight into IDLE.
  localparam state_t             RESET_STATE = (BOOT_CYCLES == 0) ? ST_IDLE : ST_BOOT;

  state_t             state, state_n;
  logic [3:0]         boot_cnt, boot_cnt_n;
  logic [PHASE_W-1:0] phase_n;
  logic [RET_W-1:0]   retired_n;
  logic               launch;
  logic               last_phase;

`ifdef PCSEQ_SINGLE_STEP_EN
  assign launch = PCSEQ_En | PCSEQ_Step;
`else
  assign launch = PCSEQ_En;
`endif

  assign last_phase = (PCSEQ_Phase == PHASE_LAST);

  always_ff @(posedge PCSEQ_Clk) begin
    if (PCSEQ_Reset) begin
      state         <= RESET_STATE;
      boot_cnt      <= '0;
      PCSEQ_Phase   <= '0;
      PCSEQ_Retired <= '0;
    end else begin
      state         <= state_n;
      boot_cnt      <= boot_cnt_n;
      PCSEQ_Phase   <= phase_n;
      PCSEQ_Retired <= retired_n;
    end
  end

  always_comb begin
    state_n    = state;
    boot_cnt_n = boot_cnt;
    phase_n    = PCSEQ_Phase;
    retired_n  = PCSEQ_Retired;
    case (state)
      ST_BOOT: begin
        boot_cnt_n = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        phase_n = '0;
        if (launch) state_n = ST_RUN;
      end
      ST_RUN: begin
        // En is only consulted on flush and at the instruction boundary.
        if (PCSEQ_Flush) begin
          phase_n = '0;
          if (!PCSEQ_En) state_n = ST_IDLE;
        end else if (!PCSEQ_Stall) begin
          if (last_phase) begin
            phase_n   = '0;
            retired_n = PCSEQ_Retired + RET_W'(1);
            if (!PCSEQ_En) state_n = ST_IDLE;
          end else begin
            phase_n = PCSEQ_Phase + PHASE_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    PCSEQ_Phase_Valid = (state == ST_RUN);
    PCSEQ_Set_En      = (state == ST_RUN) & last_phase & ~PCSEQ_Stall & ~PCSEQ_Flush & ~PCSEQ_Reset;
  end

endmodule

// File: tb/tb_pc_phase_sequencer.sv
// Bench for pc_phase_sequencer: directed vector table, random stimulus vs reference model,
// and a single-step sequence when PCSEQ_SINGLE_STEP_EN is defined.
module tb_pc_phase_sequencer;
  localparam int unsigned PHASES = 5, PHASE_W = 3, BOOT_CYCLES = 2, RET_W = 16, RET_W_S = 3;
`ifdef PCSEQ_SINGLE_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic tb_clk_50 = 1'b0;
  always #10 tb_clk_50 = ~tb_clk_50;

  logic reset, en, stall, flush, step;
  logic               set_en, valid, set_en_s, valid_s;
  logic [PHASE_W-1:0] phase, phase_s;
  logic [RET_W-1:0]   retired;
  logic [RET_W_S-1:0] retired_s;

  pc_phase_sequencer #(.PHASES(PHASES), .PHASE_W(PHASE_W), .BOOT_CYCLES(BOOT_CYCLES), .RET_W(RET_W)) dut (
    .PCSEQ_Clk(tb_clk_50), .PCSEQ_Reset(reset), .PCSEQ_En(en), .PCSEQ_Stall(stall), .PCSEQ_Flush(flush),
`ifdef PCSEQ_SINGLE_STEP_EN
    .PCSEQ_Step(step),
`endif
    .PCSEQ_Set_En(set_en), .PCSEQ_Phase(phase), .PCSEQ_Phase_Valid(valid), .PCSEQ_Retired(retired));

  // Narrow retired counter so wrap-around is reachable in a short run.
  pc_phase_sequencer #(.PHASES(PHASES), .PHASE_W(PHASE_W), .BOOT_CYCLES(BOOT_CYCLES), .RET_W(RET_W_S)) dut_s (
    .PCSEQ_Clk(tb_clk_50), .PCSEQ_Reset(reset), .PCSEQ_En(en), .PCSEQ_Stall(stall), .PCSEQ_Flush(flush),
`ifdef PCSEQ_SINGLE_STEP_EN
    .PCSEQ_Step(step),
`endif
    .PCSEQ_Set_En(set_en_s), .PCSEQ_Phase(phase_s), .PCSEQ_Phase_Valid(valid_s), .PCSEQ_Retired(retired_s));

  typedef struct {
    logic rst, en, stall, flush;
    logic set_en;
    int   phase;
    logic valid;
    int   ret;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  // Reference model: instruction-level view of the sequencer
  int m_boot_left;
  bit m_run;
  int m_phase;
  int m_ret;

  function automatic void add(logic r, logic e, logic s, logic f, logic se, int ph, logic va, int rt);
    vec_t v;
    v.rst = r; v.en = e; v.stall = s; v.flush = f;
    v.set_en = se; v.phase = ph; v.valid = va; v.ret = rt;
    vecs.push_back(v);
  endfunction

  // Rows for uninterrupted execution starting at phase ph0.
  function automatic void run_seq(int n, int ph0, int ret0, logic e);
    int ph = ph0;
    int rt = ret0;
    for (int i = 0; i < n; i++) begin
      add(1'b0, e, 1'b0, 1'b0, (ph == PHASES - 1), ph, 1'b1, rt);
      if (ph == PHASES - 1) begin ph = 0; rt++; end
      else ph++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic f, input logic st);
    @(negedge tb_clk_50);
    reset = r; en = e; stall = s; flush = f; step = st;
    #1;
  endtask

  task automatic model_step();
    if (reset) begin
      m_boot_left = BOOT_CYCLES; m_run = 0; m_phase = 0; m_ret = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (!m_run) begin
      if (en || (STEP_ON && step)) begin m_run = 1; m_phase = 0; end
    end else if (flush) begin
      m_phase = 0; m_run = en;
    end else if (!stall) begin
      if (m_phase == PHASES - 1) begin m_phase = 0; m_ret++; m_run = en; end
      else m_phase++;
    end
  endtask

  initial begin
    reset = 1; en = 0; stall = 0; flush = 0; step = 0;
    m_boot_left = 0; m_run = 0; m_phase = 0; m_ret = 0;

    add(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) add(0, 1, 0, 0, 0, 0, 0, 0);
    run_seq(12, 0, 0, 1);
    repeat (3) add(0, 1, 1, 0, 0, 2, 1, 2);
    run_seq(6, 2, 2, 1);
    add(0, 1, 0, 1, 0, 3, 1, 3);
    run_seq(9, 0, 3, 1);
    add(0, 1, 1, 1, 0, 4, 1, 4);
    run_seq(1, 0, 4, 1);
    run_seq(4, 1, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 0, 0, 0, 5);
    run_seq(3, 0, 5, 1);
    add(1, 1, 0, 0, 0, 3, 1, 5);
    repeat (3) add(0, 1, 0, 0, 0, 0, 0, 0);
    run_seq(4, 0, 0, 1);
    add(1, 1, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].flush, 1'b0);
      check($sformatf("row%0d set_en", i), 32'(set_en),  32'(vecs[i].set_en));
      check($sformatf("row%0d phase", i),  32'(phase),   32'(vecs[i].phase));
      check($sformatf("row%0d valid", i),  32'(valid),   32'(vecs[i].valid));
      check($sformatf("row%0d retired", i), 32'(retired), 32'(vecs[i].ret));
    end

    for (int c = 0; c < 3000; c++) begin
      drive((c == 0) || ($urandom_range(0, 199) == 0), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      if (c > 0) begin
        check($sformatf("rnd%0d set_en", c), 32'(set_en),
              32'(m_run && m_phase == PHASES - 1 && !stall && !flush && !reset));
        check($sformatf("rnd%0d phase", c), 32'(phase), 32'(m_run ? m_phase : 0));
        check($sformatf("rnd%0d valid", c), 32'(valid), 32'(m_run));
        check($sformatf("rnd%0d retired", c), 32'(retired), 32'(m_ret % (1 << RET_W)));
        check($sformatf("rnd%0d retired_narrow", c), 32'(retired_s), 32'(m_ret % (1 << RET_W_S)));
      end
      model_step();
    end

`ifdef PCSEQ_SINGLE_STEP_EN
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("step idle valid", 32'(valid), 32'(0));
    for (int p = 0; p < PHASES; p++) begin
      drive(0, 0, 0, 0, p == 2);
      check($sformatf("step p%0d phase", p), 32'(phase), 32'(p));
      check($sformatf("step p%0d valid", p), 32'(valid), 32'(1));
      check($sformatf("step p%0d set_en", p), 32'(set_en), 32'(p == PHASES - 1));
    end
    repeat (2) begin
      drive(0, 0, 0, 0, 0);
      check("step done valid", 32'(valid), 32'(0));
      check("step done retired", 32'(retired), 32'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
